// File: rtl/inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : inst_dispatcher
// Description : In-order instruction sequencer for the GEMM accelerator.
//               Fetches, decodes and issues LD/ST/GEMM/DRAINSYS with hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_dispatcher #(
    parameter int INST_WIDTH       = 16,
    parameter int INST_MEMORY_SIZE = 1024,
    parameter int OPCODE_WIDTH     = 4,
    parameter int BUF_ID_WIDTH     = 2,
    parameter int MEM_LOC_WIDTH    = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                imem_en,
    output logic [$clog2(INST_MEMORY_SIZE)-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0]               imem_data,
    output logic                                mem_start,
    output logic                                mem_is_store,
    output logic [BUF_ID_WIDTH-1:0]             mem_buf_id,
    output logic [MEM_LOC_WIDTH-1:0]            mem_addr,
    input  logic                                mem_done,
    output logic                                sys_start,
    output logic                                sys_is_drain,
    output logic [BUF_ID_WIDTH-1:0]             sys_buf_id,
    output logic [MEM_LOC_WIDTH-1:0]            sys_addr,
    input  logic                                sys_done,
    output logic [15:0]                         inst_count
);

    localparam int PCW = $clog2(INST_MEMORY_SIZE);

    localparam logic [OPCODE_WIDTH-1:0] c_op_nop   = OPCODE_WIDTH'('h0);
    localparam logic [OPCODE_WIDTH-1:0] c_op_ld    = OPCODE_WIDTH'('h2);
    localparam logic [OPCODE_WIDTH-1:0] c_op_st    = OPCODE_WIDTH'('h3);
    localparam logic [OPCODE_WIDTH-1:0] c_op_gemm  = OPCODE_WIDTH'('h4);
    localparam logic [OPCODE_WIDTH-1:0] c_op_drain = OPCODE_WIDTH'('h5);
    localparam logic [OPCODE_WIDTH-1:0] c_op_halt  = OPCODE_WIDTH'('hF);
    localparam logic [PCW-1:0]          c_pc_last  = PCW'(INST_MEMORY_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PCW-1:0]             r_pc;
    logic                       r_err;
    logic [15:0]                r_inst_count;
    logic                       r_mem_busy;
    logic                       r_sys_busy;
    logic [INST_WIDTH-1:0]      r_ir;
    logic                       r_ir_valid;
    logic                       r_mem_is_store;
    logic [BUF_ID_WIDTH-1:0]    r_mem_buf_id;
    logic [MEM_LOC_WIDTH-1:0]   r_mem_addr;
    logic                       r_sys_is_drain;
    logic [BUF_ID_WIDTH-1:0]    r_sys_buf_id;
    logic [MEM_LOC_WIDTH-1:0]   r_sys_addr;

    logic [INST_WIDTH-1:0]      w_inst;
    logic [OPCODE_WIDTH-1:0]    w_opcode;
    logic [BUF_ID_WIDTH-1:0]    w_bid;
    logic [MEM_LOC_WIDTH-1:0]   w_loc;
    logic                       w_mem_issue;
    logic                       w_sys_issue;
    logic                       w_advance;
    logic                       w_illegal;
    logic                       w_done;
    logic                       w_fetch;

    // Read data arrives during the first ISSUE cycle; later stall cycles use the
    // copy captured at the end of that cycle.
    assign w_inst   = r_ir_valid ? r_ir : imem_data;
    assign w_opcode = w_inst[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign w_bid    = w_inst[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
    assign w_loc    = w_inst[MEM_LOC_WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_mem_issue = 1'b0;
        w_sys_issue = 1'b0;
        w_advance   = 1'b0;
        w_illegal   = 1'b0;
        w_done      = 1'b0;
        w_fetch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_fetch     = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                case (w_opcode)
                    c_op_nop:   w_advance = 1'b1;
                    c_op_ld:    w_mem_issue = !r_mem_busy;
                    c_op_st:    w_mem_issue = !r_mem_busy && !r_sys_busy;
                    c_op_gemm,
                    c_op_drain: w_sys_issue = !r_sys_busy && !r_mem_busy;
                    c_op_halt:  w_state_nxt = S_FINISH;
                    default: begin
                        w_illegal   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end
                endcase
                if (w_mem_issue || w_sys_issue) begin
                    w_advance = 1'b1;
                end
                if (w_advance) begin
                    w_state_nxt = (r_pc == c_pc_last) ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                if (!r_mem_busy && !r_sys_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_err          <= 1'b0;
            r_inst_count   <= '0;
            r_mem_busy     <= 1'b0;
            r_sys_busy     <= 1'b0;
            r_ir           <= '0;
            r_ir_valid     <= 1'b0;
            r_mem_is_store <= 1'b0;
            r_mem_buf_id   <= '0;
            r_mem_addr     <= '0;
            r_sys_is_drain <= 1'b0;
            r_sys_buf_id   <= '0;
            r_sys_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_inst;
            r_ir_valid <= (r_state == S_ISSUE) && (w_state_nxt == S_ISSUE);

            if (r_state == S_IDLE && start) begin
                r_pc         <= '0;
                r_err        <= 1'b0;
                r_inst_count <= '0;
            end

            if (w_advance) begin
                if (r_inst_count != 16'hFFFF) begin
                    r_inst_count <= r_inst_count + 16'd1;
                end
                // The last slot retires but flags an overrun instead of wrapping.
                if (r_pc == c_pc_last) begin
                    r_err <= 1'b1;
                end else begin
                    r_pc <= r_pc + PCW'(1);
                end
            end

            if (w_illegal) begin
                r_err <= 1'b1;
            end

            if (w_mem_issue) begin
                r_mem_is_store <= (w_opcode == c_op_st);
                r_mem_buf_id   <= w_bid;
                r_mem_addr     <= w_loc;
                r_mem_busy     <= 1'b1;
            end else if (mem_done) begin
                r_mem_busy     <= 1'b0;
            end

            if (w_sys_issue) begin
                r_sys_is_drain <= (w_opcode == c_op_drain);
                r_sys_buf_id   <= w_bid;
                r_sys_addr     <= w_loc;
                r_sys_busy     <= 1'b1;
            end else if (sys_done) begin
                r_sys_busy     <= 1'b0;
            end
        end
    end

    // Held fields show the new values in the same cycle as the start pulse.
    assign mem_start    = w_mem_issue;
    assign mem_is_store = w_mem_issue ? (w_opcode == c_op_st) : r_mem_is_store;
    assign mem_buf_id   = w_mem_issue ? w_bid : r_mem_buf_id;
    assign mem_addr     = w_mem_issue ? w_loc : r_mem_addr;
    assign sys_start    = w_sys_issue;
    assign sys_is_drain = w_sys_issue ? (w_opcode == c_op_drain) : r_sys_is_drain;
    assign sys_buf_id   = w_sys_issue ? w_bid : r_sys_buf_id;
    assign sys_addr     = w_sys_issue ? w_loc : r_sys_addr;

    assign busy       = (r_state != S_IDLE);
    assign done       = w_done;
    assign err        = r_err;
    assign imem_en    = w_fetch;
    assign imem_addr  = r_pc;
    assign inst_count = r_inst_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_dispatcher
// Description : Scoreboard bench for inst_dispatcher with unit response models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_dispatcher;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data;
    logic        mem_start;
    logic        mem_is_store;
    logic [1:0]  mem_buf_id;
    logic [9:0]  mem_addr;
    logic        mem_done;
    logic        sys_start;
    logic        sys_is_drain;
    logic [1:0]  sys_buf_id;
    logic [9:0]  sys_addr;
    logic        sys_done;
    logic [15:0] inst_count;

    inst_dispatcher dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .mem_start(mem_start), .mem_is_store(mem_is_store), .mem_buf_id(mem_buf_id),
        .mem_addr(mem_addr), .mem_done(mem_done),
        .sys_start(sys_start), .sys_is_drain(sys_is_drain), .sys_buf_id(sys_buf_id),
        .sys_addr(sys_addr), .sys_done(sys_done), .inst_count(inst_count)
    );

    typedef struct packed {
        logic       is_sys;
        logic       flag;
        logic [1:0] bid;
        logic [9:0] addr;
    } exp_t;

    localparam logic [3:0] c_nop = 4'h0, c_ld = 4'h2, c_st = 4'h3,
                           c_gemm = 4'h4, c_drain = 4'h5, c_halt = 4'hF;

    logic [15:0] imem [1024];
    exp_t        sb_q[$];
    int          mem_start_cycs[$];
    int          sys_start_cycs[$];
    int          mem_done_cycs[$];
    int          sys_done_cycs[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          max_addr = 0;
    int          mem_lat = 3;
    int          sys_lat = 3;
    int          mem_cnt = 0;
    int          sys_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] b, input logic [9:0] a);
        return {op, b, a};
    endfunction

    task automatic expect_issue(input logic is_sys, input logic flag, input logic [1:0] b, input logic [9:0] a);
        exp_t e;
        e.is_sys = is_sys;
        e.flag   = flag;
        e.bid    = b;
        e.addr   = a;
        sb_q.push_back(e);
    endtask

    task automatic score_issue(input exp_t got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("issue_fields", 32'(got), 32'(e));
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) imem[i] = enc(c_halt, 2'd0, 10'd0);
        sb_q.delete();
        mem_start_cycs.delete();
        sys_start_cycs.delete();
        mem_done_cycs.delete();
        sys_done_cycs.delete();
    endtask

    task automatic kick();
        done_cnt = 0;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("idle_after", {31'd0, busy}, 0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) begin
        if (imem_en) imem_data <= imem[imem_addr];
    end

    // Output monitor: issues against the scoreboard, done pulses, fetch range.
    initial forever begin
        @(negedge clk);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (imem_en && int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
        if (mem_start) begin
            mem_start_cycs.push_back(cyc);
            score_issue({1'b0, mem_is_store, mem_buf_id, mem_addr});
        end
        if (sys_start) begin
            sys_start_cycs.push_back(cyc);
            score_issue({1'b1, sys_is_drain, sys_buf_id, sys_addr});
        end
    end

    // Unit models: a done pulse a fixed latency after each start pulse.
    initial begin
        mem_done = 1'b0;
        sys_done = 1'b0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            sys_done = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_done = 1'b1;
                    mem_done_cycs.push_back(cyc);
                end
            end
            if (sys_cnt > 0) begin
                sys_cnt--;
                if (sys_cnt == 0) begin
                    sys_done = 1'b1;
                    sys_done_cycs.push_back(cyc);
                end
            end
            if (mem_start) mem_cnt = mem_lat;
            if (sys_start) sys_cnt = sys_lat;
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        imem_data = '0;
        clear_prog();
        repeat (3) @(negedge clk);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 0);
        check("rst_strobes", {29'd0, imem_en, mem_start, sys_start}, 0);
        check("rst_mem_fields", {19'd0, mem_is_store, mem_buf_id, mem_addr}, 0);
        check("rst_sys_fields", {19'd0, sys_is_drain, sys_buf_id, sys_addr}, 0);
        check("rst_count_addr", {6'd0, inst_count, imem_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: LD then GEMM; GEMM issues the cycle after mem_done
        clear_prog();
        mem_lat = 5; sys_lat = 3;
        imem[0] = enc(c_ld, 2'd1, 10'h010);
        imem[1] = enc(c_gemm, 2'd0, 10'h000);
        expect_issue(1'b0, 1'b0, 2'd1, 10'h010);
        expect_issue(1'b1, 1'b0, 2'd0, 10'h000);
        kick();
        wait_done(100);
        check("t1_ld_cycle", mem_start_cycs.size() > 0 ? mem_start_cycs[0] - start_cyc : -1, 2);
        check("t1_gemm_after_done", (sys_start_cycs.size() > 0 && mem_done_cycs.size() > 0) ?
              sys_start_cycs[0] - mem_done_cycs[0] : -1, 1);
        check("t1_done_cycle", done_cyc - start_cyc, 12);
        check("t1_count", inst_count, 2);
        check("t1_err", {31'd0, err}, 0);

        // 2: back-to-back LDs; second waits for first mem_done
        clear_prog();
        mem_lat = 3;
        imem[0] = enc(c_ld, 2'd1, 10'h020);
        imem[1] = enc(c_ld, 2'd2, 10'h030);
        expect_issue(1'b0, 1'b0, 2'd1, 10'h020);
        expect_issue(1'b0, 1'b0, 2'd2, 10'h030);
        kick();
        n = 0;
        while (mem_start_cycs.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mem_start_cycs.size() == 0) begin
            check("t2_first_issue_timeout", 32'd0, 32'd1);
        end else begin
            while (cyc < mem_start_cycs[0] + 2) @(negedge clk);
            check("t2_addr_held_in_stall", {21'd0, mem_start, mem_addr}, {21'd0, 1'b0, 10'h020});
        end
        wait_done(100);
        check("t2_second_issue", (mem_start_cycs.size() > 1 && mem_done_cycs.size() > 0) ?
              mem_start_cycs[1] - mem_done_cycs[0] : -1, 1);
        check("t2_count", inst_count, 2);

        // 3: GEMM, DRAINSYS, ST waits on the systolic unit
        clear_prog();
        mem_lat = 4; sys_lat = 8;
        imem[0] = enc(c_gemm, 2'd1, 10'h005);
        imem[1] = enc(c_drain, 2'd3, 10'h006);
        imem[2] = enc(c_st, 2'd2, 10'h3FF);
        expect_issue(1'b1, 1'b0, 2'd1, 10'h005);
        expect_issue(1'b1, 1'b1, 2'd3, 10'h006);
        expect_issue(1'b0, 1'b1, 2'd2, 10'h3FF);
        kick();
        wait_done(200);
        check("t3_drain_cycle", sys_start_cycs.size() > 1 ? sys_start_cycs[1] - start_cyc : -1, 11);
        check("t3_st_after_sysdone", (mem_start_cycs.size() > 0 && sys_done_cycs.size() > 1) ?
              mem_start_cycs[0] - sys_done_cycs[1] : -1, 1);
        check("t3_done_after_memdone", mem_done_cycs.size() > 0 ? done_cyc - mem_done_cycs[0] : -1, 1);
        check("t3_count", inst_count, 3);

        // 4: illegal opcode after two NOPs
        clear_prog();
        imem[0] = enc(c_nop, 2'd0, 10'd0);
        imem[1] = enc(c_nop, 2'd0, 10'd0);
        imem[2] = 16'hA000;
        kick();
        wait_done(50);
        check("t4_err", {31'd0, err}, 1);
        check("t4_count", inst_count, 2);
        check("t4_done_cycle", done_cyc - start_cyc, 7);
        check("t4_no_issue", mem_start_cycs.size() + sys_start_cycs.size(), 0);

        // 5: reset while stalled on mem_done; late done ignored; restart from PC 0
        clear_prog();
        mem_lat = 20;
        imem[0] = enc(c_ld, 2'd1, 10'h011);
        imem[1] = enc(c_ld, 2'd2, 10'h022);
        expect_issue(1'b0, 1'b0, 2'd1, 10'h011);
        kick();
        check("t5_err_cleared_by_start", {31'd0, err}, 0);
        n = 0;
        while (mem_start_cycs.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_issue_seen", mem_start_cycs.size(), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_status", {28'd0, busy, done, err, imem_en}, 0);
        check("t5_rst_mem", {18'd0, mem_start, mem_is_store, mem_buf_id, mem_addr}, 0);
        check("t5_rst_count_pc", {6'd0, inst_count, imem_addr}, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_late_done_delivered", mem_done_cycs.size(), 1);
        check("t5_idle_after_late_done", {31'd0, busy}, 0);
        clear_prog();
        mem_lat = 2;
        imem[0] = enc(c_ld, 2'd3, 10'h033);
        expect_issue(1'b0, 1'b0, 2'd3, 10'h033);
        kick();
        wait_done(50);
        check("t5_restart_issue", mem_start_cycs.size() > 0 ? mem_start_cycs[0] - start_cyc : -1, 2);
        check("t5_restart_count", inst_count, 1);

        // 6: all NOPs run off the end of memory
        clear_prog();
        for (int i = 0; i < 1024; i++) imem[i] = enc(c_nop, 2'd0, 10'd0);
        max_addr = 0;
        kick();
        wait_done(2300);
        check("t6_err", {31'd0, err}, 1);
        check("t6_count", inst_count, 16'h0400);
        check("t6_max_pc", max_addr, 1023);
        check("t6_done_cycle", done_cyc - start_cyc, 2049);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
